// File: rtl/adder_result_buffer.sv
// Result buffer behind the 64-bit pipelined adder: FWFT FIFO with a valid/ready drain
// and saturating statistics for dropped results and carry-outs.
module adder_result_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_en,
  input  logic [DATA_WIDTH:0]        in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_carry,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       drop_cnt,
  output logic [CNT_WIDTH-1:0]       carry_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WORD_W = DATA_WIDTH + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("adder_result_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WORD_W-1:0] head;
  logic              push;
  logic              pop;
  logic              drop;

  // Status flags come straight from the registered occupancy.
  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == LVL_W'(0));
  assign out_valid = !empty;

  assign pop  = out_valid && out_ready;
  assign push = in_en && (!full || pop);
  assign drop = in_en && full && !pop;

  // Head is gated so an empty buffer never exposes stale memory.
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_carry = out_valid ? head[DATA_WIDTH]     : 1'b0;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= LVL_W'(level + 1'b1);
        2'b01:   level <= LVL_W'(level - 1'b1);
        default: level <= level;
      endcase
    end
  end

  // Saturating counters; a dropped result never reaches carry_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt  <= '0;
      carry_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= CNT_WIDTH'(drop_cnt + 1'b1);
      end
      if (push && in_result[DATA_WIDTH] && (carry_cnt != '1)) begin
        carry_cnt <= CNT_WIDTH'(carry_cnt + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed bench for adder_result_buffer; inputs are driven and outputs sampled 1ns after each rising edge.
module tb_adder_result_buffer;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic          in_en;
  logic [DW:0]   in_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_carry;
  logic          full;
  logic          empty;
  logic [3:0]    level;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] carry_cnt;

  int vectors    = 0;
  int miscompares = 0;

  adder_result_buffer #(.DATA_WIDTH(DW), .DEPTH(8), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .carry_cnt (carry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_en = 1'b0; in_result = '0; out_ready = 1'b0;
    #12;
    vectors++;
    if ({out_valid, empty, full, level} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_flags: got valid/empty/full/level=%b/%b/%b/%0d want 0/1/0/0",
               out_valid, empty, full, level);
    end
    vectors++;
    if ({out_data, out_carry, drop_cnt, carry_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got data=%h carry=%b drop=%0d carry_cnt=%0d want all 0",
               out_data, out_carry, drop_cnt, carry_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    in_en = 1'b1; in_result = 65'h1_0000_0000_0000_0001;
    step();
    in_en = 1'b0;
    vectors++;
    if ({out_valid, out_carry, out_data} !== {1'b1, 1'b1, 64'h1}) begin
      miscompares++;
      $display("FAIL single_head: got valid=%b carry=%b data=%h want 1 1 1", out_valid, out_carry, out_data);
    end
    vectors++;
    if ({level, carry_cnt} !== {4'd1, 16'd1}) begin
      miscompares++;
      $display("FAIL single_stats: got level=%0d carry_cnt=%0d want 1 1", level, carry_cnt);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if ({empty, level, out_valid, out_data} !== {1'b1, 4'd0, 1'b0, 64'h0}) begin
      miscompares++;
      $display("FAIL single_pop: got empty=%b level=%0d valid=%b data=%h want 1 0 0 0",
               empty, level, out_valid, out_data);
    end
  endtask

  task automatic test_burst_full();
    for (int i = 0; i < 8; i++) begin
      in_en = 1'b1; in_result = {1'b0, 64'(i)};
      step();
    end
    vectors++;
    if ({full, level} !== {1'b1, 4'd8}) begin
      miscompares++;
      $display("FAIL burst_full: got full=%b level=%0d want 1 8", full, level);
    end
    in_result = {1'b1, 64'd99};
    step();
    in_en = 1'b0;
    vectors++;
    if ({drop_cnt, level, carry_cnt, out_data} !== {16'd1, 4'd8, 16'd1, 64'd0}) begin
      miscompares++;
      $display("FAIL burst_drop: got drop=%0d level=%0d carry_cnt=%0d head=%h want 1 8 1 0",
               drop_cnt, level, carry_cnt, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({out_valid, out_data} !== {1'b1, 64'(i)}) begin
        miscompares++;
        $display("FAIL burst_drain[%0d]: got valid=%b data=%h want 1 %h", i, out_valid, out_data, 64'(i));
      end
      step();
    end
    out_ready = 1'b0;
    vectors++;
    if ({empty, level} !== {1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL burst_empty: got empty=%b level=%0d want 1 0", empty, level);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      in_en = 1'b1; in_result = {1'b0, 64'(i)};
      step();
    end
    in_result = {1'b0, 64'd8}; out_ready = 1'b1;
    vectors++;
    if ({full, out_data} !== {1'b1, 64'd0}) begin
      miscompares++;
      $display("FAIL fpp_head: got full=%b data=%h want 1 0", full, out_data);
    end
    step();
    in_en = 1'b0; out_ready = 1'b0;
    vectors++;
    if ({level, drop_cnt, out_data} !== {4'd8, 16'd1, 64'd1}) begin
      miscompares++;
      $display("FAIL fpp_after: got level=%0d drop=%0d head=%h want 8 1 1", level, drop_cnt, out_data);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if ({out_valid, out_data} !== {1'b1, 64'(i)}) begin
        miscompares++;
        $display("FAIL fpp_drain[%0d]: got valid=%b data=%h want 1 %h", i, out_valid, out_data, 64'(i));
      end
      step();
    end
    out_ready = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fpp_empty: got empty=%b want 1", empty);
    end
  endtask

  task automatic test_wrap();
    int next_out = 0;
    int max_lvl  = 0;
    for (int c = 0; c < 22; c++) begin
      logic [63:0] cv;
      cv        = 64'(c);
      in_en     = (c < 20);
      in_result = {cv[0], 64'(100 + c)};
      out_ready = (c >= 2);
      if (out_valid && out_ready) begin
        logic [63:0] nv;
        nv = 64'(next_out);
        vectors++;
        if ({out_carry, out_data} !== {nv[0], 64'(100 + next_out)}) begin
          miscompares++;
          $display("FAIL wrap[%0d]: got carry=%b data=%h want %b %h",
                   next_out, out_carry, out_data, nv[0], 64'(100 + next_out));
        end
        next_out++;
      end
      step();
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    in_en = 1'b0; out_ready = 1'b0;
    vectors++;
    if (next_out != 20 || empty !== 1'b1 || max_lvl > 3) begin
      miscompares++;
      $display("FAIL wrap_done: got popped=%0d empty=%b max_level=%0d want 20 1 <=3", next_out, empty, max_lvl);
    end
    vectors++;
    if (carry_cnt !== 16'd11) begin
      miscompares++;
      $display("FAIL wrap_carry_cnt: got %0d want 11", carry_cnt);
    end
  endtask

  task automatic test_back_pressure();
    in_en = 1'b1; in_result = {1'b1, 64'hDEAD_BEEF_CAFE_F00D};
    step();
    in_en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({out_valid, out_carry, out_data} !== {1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D}) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: got valid=%b carry=%b data=%h want 1 1 deadbeefcafef00d",
                 i, out_valid, out_carry, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if ({empty, carry_cnt} !== {1'b1, 16'd12}) begin
      miscompares++;
      $display("FAIL backpressure_end: got empty=%b carry_cnt=%0d want 1 12", empty, carry_cnt);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      in_en = 1'b1; in_result = {1'b1, 64'(200 + i)};
      step();
    end
    in_en = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    vectors++;
    if ({level, drop_cnt, carry_cnt, out_data} !== {4'd5, 16'd3, 16'd20, 64'd203}) begin
      miscompares++;
      $display("FAIL areset_pre: got level=%0d drop=%0d carry_cnt=%0d head=%h want 5 3 20 cb",
               level, drop_cnt, carry_cnt, out_data);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({empty, full, out_valid, level, drop_cnt, carry_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL areset_now: got empty=%b full=%b valid=%b level=%0d drop=%0d carry_cnt=%0d want 1 0 0 0 0 0",
               empty, full, out_valid, level, drop_cnt, carry_cnt);
    end
    vectors++;
    if ({out_data, out_carry} !== '0) begin
      miscompares++;
      $display("FAIL areset_data: got data=%h carry=%b want 0 0", out_data, out_carry);
    end
    @(negedge clk);
    rst = 1'b0;
    in_en = 1'b1; in_result = 65'h0_FFFF_FFFF_FFFF_FFFF;
    step();
    in_en = 1'b0;
    vectors++;
    if ({out_valid, out_carry, out_data, level, carry_cnt, drop_cnt} !==
        {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 16'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL areset_after: got valid=%b carry=%b data=%h level=%0d carry_cnt=%0d drop=%0d want 1 0 ffffffffffffffff 1 0 0",
               out_valid, out_carry, out_data, level, carry_cnt, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_full();
    test_full_push_pop();
    test_wrap();
    test_back_pressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
